// File: rtl/branch_train_queue.sv
// Branch training queue: buffers resolved branch outcomes from ROB commit
// and presents them in commit order to the predictor, with perf counters.
module branch_train_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             commit_valid,
  input  logic             commit_is_branch,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_ins,
  input  logic             commit_taken,
  input  logic             commit_mispredict,
  output logic             commit_ready,
  output logic             enable_from_rob,
  input  logic             train_ready,
  output logic             if_jump,
  output logic [31:0]      code,
  output logic [31:0]      train_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_pc  [DEPTH];
  logic [31:0]      r_ins [DEPTH];
  logic [DEPTH-1:0] r_taken;
  logic [CNT_W-1:0] r_branch_cnt, r_mispredict_cnt;
  logic             w_full, w_empty, w_push, w_pop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Push is gated by full only, so a same-cycle pop never frees a slot early.
  assign w_push  = rdy & commit_valid & commit_is_branch & ~w_full;
  assign w_pop   = rdy & ~w_empty & train_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr         <= '0;
      r_wr_ptr         <= '0;
      r_count          <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
        r_branch_cnt     <= r_branch_cnt + CNT_W'(1);
        r_mispredict_cnt <= r_mispredict_cnt + CNT_W'(commit_mispredict);
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr_ptr]    <= commit_pc;
      r_ins[r_wr_ptr]   <= commit_ins;
      r_taken[r_wr_ptr] <= commit_taken;
    end
  end

  assign commit_ready    = ~w_full;
  assign enable_from_rob = ~w_empty;
  assign if_jump         = w_empty ? 1'b0  : r_taken[r_rd_ptr];
  assign code            = w_empty ? 32'd0 : r_ins[r_rd_ptr];
  assign train_pc        = w_empty ? 32'd0 : r_pc[r_rd_ptr];
  assign branch_cnt      = r_branch_cnt;
  assign mispredict_cnt  = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_train_queue.sv
// Directed bench for branch_train_queue: reset, single entry, fill/drain,
// full push+pop with wrap, mixed commit stream, async reset with rdy stall.
module tb_branch_train_queue;
  logic        clk = 1'b0;
  logic        rst, rdy, commit_valid, commit_is_branch;
  logic [31:0] commit_pc, commit_ins;
  logic        commit_taken, commit_mispredict;
  logic        commit_ready, enable_from_rob, train_ready, if_jump;
  logic [31:0] code, train_pc;
  logic [31:0] branch_cnt, mispredict_cnt;

  int checks = 0;
  int errs   = 0;

  branch_train_queue #(.DEPTH(8), .PTR_W(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .commit_valid(commit_valid), .commit_is_branch(commit_is_branch),
    .commit_pc(commit_pc), .commit_ins(commit_ins),
    .commit_taken(commit_taken), .commit_mispredict(commit_mispredict),
    .commit_ready(commit_ready), .enable_from_rob(enable_from_rob),
    .train_ready(train_ready), .if_jump(if_jump), .code(code),
    .train_pc(train_pc), .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    commit_valid = 0; commit_is_branch = 0; commit_pc = 0; commit_ins = 0;
    commit_taken = 0; commit_mispredict = 0; train_ready = 0; rdy = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  task automatic drive_branch(input logic [31:0] pc, input logic [31:0] ins,
                              input logic tk, input logic mp);
    commit_valid = 1; commit_is_branch = 1; commit_pc = pc; commit_ins = ins;
    commit_taken = tk; commit_mispredict = mp;
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++; if (enable_from_rob !== 1'b0) begin errs++; $display("FAIL reset_enable: got %0b want 0", enable_from_rob); end
    checks++; if (commit_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %0b want 1", commit_ready); end
    checks++; if (branch_cnt !== 32'd0) begin errs++; $display("FAIL reset_branch_cnt: got %0d want 0", branch_cnt); end
    checks++; if (mispredict_cnt !== 32'd0) begin errs++; $display("FAIL reset_mp_cnt: got %0d want 0", mispredict_cnt); end
    checks++; if ({if_jump, code, train_pc} !== 65'd0) begin errs++; $display("FAIL reset_head: got %0b %h %h want zeros", if_jump, code, train_pc); end
  endtask

  task automatic test_single();
    do_reset();
    drive_branch(32'h0000_1000, 32'h0020_8463, 1'b1, 1'b0);
    train_ready = 1;
    checks++; if (enable_from_rob !== 1'b0) begin errs++; $display("FAIL single_no_bypass: got %0b want 0", enable_from_rob); end
    step();
    commit_valid = 0;
    checks++; if (enable_from_rob !== 1'b1) begin errs++; $display("FAIL single_enable: got %0b want 1", enable_from_rob); end
    checks++; if (code !== 32'h0020_8463) begin errs++; $display("FAIL single_code: got %h want 00208463", code); end
    checks++; if (train_pc !== 32'h0000_1000) begin errs++; $display("FAIL single_pc: got %h want 00001000", train_pc); end
    checks++; if (if_jump !== 1'b1) begin errs++; $display("FAIL single_jump: got %0b want 1", if_jump); end
    step();
    checks++; if (enable_from_rob !== 1'b0) begin errs++; $display("FAIL single_drained: got %0b want 0", enable_from_rob); end
    checks++; if (branch_cnt !== 32'd1) begin errs++; $display("FAIL single_cnt: got %0d want 1", branch_cnt); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive_branch(32'h100 + 4 * i, 32'hA000_0000 + i, i[0], 1'b0);
      step();
    end
    checks++; if (commit_ready !== 1'b0) begin errs++; $display("FAIL fill_ready: got %0b want 0", commit_ready); end
    drive_branch(32'h120, 32'hA000_0008, 1'b0, 1'b0);
    step();
    checks++; if (branch_cnt !== 32'd8) begin errs++; $display("FAIL fill_held_cnt: got %0d want 8", branch_cnt); end
    checks++; if (train_pc !== 32'h100) begin errs++; $display("FAIL fill_head: got %h want 100", train_pc); end
    commit_valid = 0;
    train_ready = 1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (train_pc !== 32'h100 + 4 * i || code !== 32'hA000_0000 + i || if_jump !== i[0]) begin
        errs++; $display("FAIL drain_order[%0d]: got pc=%h ins=%h tk=%0b want pc=%h ins=%h tk=%0b",
                         i, train_pc, code, if_jump, 32'h100 + 4 * i, 32'hA000_0000 + i, i[0]);
      end
      step();
      if (i == 0) begin
        checks++; if (commit_ready !== 1'b1) begin errs++; $display("FAIL drain_ready: got %0b want 1", commit_ready); end
      end
    end
    checks++; if (enable_from_rob !== 1'b0) begin errs++; $display("FAIL drain_empty: got %0b want 0", enable_from_rob); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive_branch(32'h200 + 4 * k, 32'hB000_0000 + k, 1'b0, 1'b0);
      step();
    end
    // Full: simultaneous pop must not let the push in.
    drive_branch(32'h220, 32'hB000_0008, 1'b0, 1'b0);
    train_ready = 1;
    step();
    checks++; if (branch_cnt !== 32'd8) begin errs++; $display("FAIL full_pp_reject: got %0d want 8", branch_cnt); end
    checks++; if (commit_ready !== 1'b1) begin errs++; $display("FAIL full_pp_ready: got %0b want 1", commit_ready); end
    checks++; if (train_pc !== 32'h204) begin errs++; $display("FAIL full_pp_head: got %h want 204", train_pc); end
    step();
    checks++; if (branch_cnt !== 32'd9) begin errs++; $display("FAIL pp_accept: got %0d want 9", branch_cnt); end
    checks++; if (commit_ready !== 1'b1) begin errs++; $display("FAIL pp_count7: got %0b want 1", commit_ready); end
    checks++; if (train_pc !== 32'h208) begin errs++; $display("FAIL pp_head: got %h want 208", train_pc); end
    for (int j = 0; j < 11; j++) begin
      drive_branch(32'h200 + 4 * (9 + j), 32'hB000_0000 + 9 + j, 1'b0, 1'b0);
      step();
      checks++; if (train_pc !== 32'h200 + 4 * (3 + j) || commit_ready !== 1'b1) begin
        errs++; $display("FAIL wrap_stream[%0d]: got pc=%h rdy=%0b want pc=%h rdy=1",
                         j, train_pc, commit_ready, 32'h200 + 4 * (3 + j));
      end
    end
    commit_valid = 0;
    for (int d = 0; d < 7; d++) begin
      checks++; if (train_pc !== 32'h200 + 4 * (13 + d) || code !== 32'hB000_0000 + 13 + d) begin
        errs++; $display("FAIL wrap_drain[%0d]: got pc=%h ins=%h want pc=%h", d, train_pc, code, 32'h200 + 4 * (13 + d));
      end
      step();
    end
    checks++; if (enable_from_rob !== 1'b0) begin errs++; $display("FAIL wrap_empty: got %0b want 0", enable_from_rob); end
    checks++; if (branch_cnt !== 32'd20) begin errs++; $display("FAIL wrap_cnt: got %0d want 20", branch_cnt); end
  endtask

  task automatic test_mixed();
    logic [31:0] exp_pc [4];
    int n;
    exp_pc[0] = 32'h300; exp_pc[1] = 32'h304; exp_pc[2] = 32'h308; exp_pc[3] = 32'h30C;
    do_reset();
    drive_branch(32'h900, 32'h0, 1'b1, 1'b1); commit_is_branch = 0; step();
    drive_branch(32'h300, 32'h1, 1'b1, 1'b1); step();
    drive_branch(32'h904, 32'h0, 1'b1, 1'b1); commit_is_branch = 0; step();
    drive_branch(32'h304, 32'h2, 1'b0, 1'b0); step();
    drive_branch(32'h308, 32'h3, 1'b1, 1'b1); step();
    drive_branch(32'h908, 32'h0, 1'b0, 1'b1); commit_is_branch = 0; step();
    drive_branch(32'h30C, 32'h4, 1'b0, 1'b0); step();
    commit_valid = 0;
    checks++; if (branch_cnt !== 32'd4) begin errs++; $display("FAIL mixed_branch_cnt: got %0d want 4", branch_cnt); end
    checks++; if (mispredict_cnt !== 32'd2) begin errs++; $display("FAIL mixed_mp_cnt: got %0d want 2", mispredict_cnt); end
    train_ready = 1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (enable_from_rob) begin
        if (n < 4) begin
          checks++; if (train_pc !== exp_pc[n]) begin errs++; $display("FAIL mixed_order[%0d]: got %h want %h", n, train_pc, exp_pc[n]); end
        end
        n++;
      end
      step();
    end
    checks++; if (n !== 4) begin errs++; $display("FAIL mixed_emitted: got %0d want 4", n); end
    checks++; if (branch_cnt !== 32'd4) begin errs++; $display("FAIL mixed_cnt_after_pop: got %0d want 4", branch_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_branch(32'h400 + 4 * i, 32'hC000_0000 + i, 1'b1, 1'b1);
      step();
    end
    rdy = 0;
    drive_branch(32'h500, 32'hD000_0000, 1'b1, 1'b1);
    train_ready = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (branch_cnt !== 32'd5 || mispredict_cnt !== 32'd5 || train_pc !== 32'h400 || enable_from_rob !== 1'b1) begin
        errs++; $display("FAIL rdy_hold[%0d]: got cnt=%0d mp=%0d pc=%h en=%0b want 5 5 400 1",
                         c, branch_cnt, mispredict_cnt, train_pc, enable_from_rob);
      end
    end
    #2 rst = 0;
    #1;
    checks++; if (enable_from_rob !== 1'b0 || commit_ready !== 1'b1 || train_pc !== 32'd0) begin
      errs++; $display("FAIL async_clear: got en=%0b rdy=%0b pc=%h want 0 1 0", enable_from_rob, commit_ready, train_pc);
    end
    checks++; if (branch_cnt !== 32'd0 || mispredict_cnt !== 32'd0) begin
      errs++; $display("FAIL async_cnt: got %0d %0d want 0 0", branch_cnt, mispredict_cnt);
    end
    idle_inputs();
    train_ready = 1;
    @(negedge clk);
    rst = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      checks++; if (enable_from_rob !== 1'b0) begin errs++; $display("FAIL post_reset_spurious[%0d]: got %0b want 0", c, enable_from_rob); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_fill_drain();
    test_back_to_back();
    test_mixed();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/branch_train_queue.md
Name: branch_train_queue

Overview:
- Sits at the ROB commit port and produces the predictor training stream: enable_from_rob, if_jump, code.
- Buffers resolved branch outcomes from committed instructions in a small FIFO.
- Delivers one training update per accepted handshake to the predictor.
- Keeps architectural branch and mispredict counters for performance debug.

Parameters:
- DEPTH, 8, FIFO entries; must be a power of 2, at least 2.
- PTR_W, 3, log2(DEPTH).
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy  input  1  global ready; when 0, all state holds and no push or pop occurs.
- commit_valid  input  1  ROB commits an instruction this cycle.
- commit_is_branch  input  1  committed instruction is a conditional branch or JALR.
- commit_pc  input  32  PC of the committed instruction.
- commit_ins  input  32  raw instruction word.
- commit_taken  input  1  resolved direction, 1 = taken.
- commit_mispredict  input  1  prediction was wrong.
- commit_ready  output  1  queue can accept a branch commit this cycle.
- enable_from_rob  output  1  training entry valid (FIFO head).
- train_ready  input  1  predictor consumes the head this cycle.
- if_jump  output  1  head entry taken bit.
- code  output  32  head entry instruction word.
- train_pc  output  32  head entry PC.
- branch_cnt  output  CNT_W  total branches accepted.
- mispredict_cnt  output  CNT_W  total mispredicted branches accepted.

Behaviour:
- Reset (rst=0, asynchronous): rd_ptr, wr_ptr and count clear to 0. Both counters clear to 0.
- Reset output values: enable_from_rob=0, commit_ready=1, if_jump=0, code=0, train_pc=0. Entry storage contents need not reset.
- Reset mid-operation: all queued entries are discarded. Nothing is emitted in the cycle after rst deasserts.
- FIFO state:
  - count is PTR_W+1 bits wide.
  - full = (count == DEPTH); empty = (count == 0).
  - Pointers are PTR_W bits and wrap naturally from DEPTH-1 to 0.
- commit_ready = !full. It is combinational from registered count and does not depend on train_ready.
- push = rdy & commit_valid & commit_is_branch & !full.
  - Writes {commit_pc, commit_ins, commit_taken} at wr_ptr; wr_ptr increments.
- Commits with commit_is_branch=0 are ignored entirely: no push, no counter change.
- If a branch commit arrives while full, it is not accepted. The ROB must hold it until commit_ready=1.
- enable_from_rob = !empty.
  - if_jump, code and train_pc are driven from the entry at rd_ptr, combinational read of registered storage.
  - When empty, these three outputs are forced to 0.
- pop = rdy & enable_from_rob & train_ready; rd_ptr increments.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - When full, push is blocked even if a pop occurs in the same cycle.
  - When empty, only the push takes effect.
- Latency: a branch accepted in cycle N appears on enable_from_rob in cycle N+1 when the queue was empty. There is no bypass.
- Ordering: strict FIFO, identical to commit order.
- Counters:
  - branch_cnt += 1 on every push.
  - mispredict_cnt += 1 on every push with commit_mispredict=1.
  - Both wrap modulo 2^CNT_W.
  - Counters are not affected by pop.
- rdy=0: no push, no pop, counters hold. Outputs still reflect current state.

Test Plan:
- Reset, then idle → enable_from_rob=0, commit_ready=1, branch_cnt=0, mispredict_cnt=0.
- Single branch: pc=0x00001000, ins=0x00208463, taken=1, train_ready=1.
  → The cycle after acceptance shows enable_from_rob=1, code=0x00208463, train_pc=0x00001000, if_jump=1.
  → The cycle after that shows enable_from_rob=0; branch_cnt=1.
- train_ready=0; push 8 branches with pc=0x100,0x104..0x11C.
  → commit_ready=0 after the 8th.
  → A 9th commit is held and not counted (branch_cnt=8).
  → Raising train_ready drains pcs in order 0x100..0x11C, and commit_ready returns to 1 after the first pop.
- Full queue with push and pop in the same cycle → push is rejected, count drops to 7.
  → Next cycle push and pop both occur and count stays 7.
  → Wrap-around keeps order correct across 20 entries.
- Mixed commit stream: 3 non-branch, 4 branch of which 2 have mispredict=1.
  → Exactly 4 entries are emitted; branch_cnt=4, mispredict_cnt=2.
- Assert rst=0 asynchronously with 5 entries queued and rdy held 0 for 3 cycles.
  → The queue empties immediately.
  → After release there is no spurious enable_from_rob.
  → During rdy=0 no state changes even with commit_valid=1 and train_ready=1.
